ysyx_23060124_idu: RTL and testbench

// Instruction decode stage, directly downstream of the instruction fetch unit. Accepts {instruction, pc}

---
 rtl/ysyx_23060124_idu.sv | 145 ++++++++++++++
 tb/tb_ysyx_23060124_idu.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060124_idu.sv
// ysyx_23060124_idu: instruction decode stage with a one-entry pipeline register.
// Fetch hands over {instruction, pc} through valid/ready. Execute takes the decoded fields through valid/ready.
// A redirect flush drops both the held instruction and the incoming one.
// Optional macro IDU_RV32E_EN selects the RV32E register space:
//   - register indices shrink to 4 bits;
//   - an instruction that uses any register field above x15 is flagged illegal.
module ysyx_23060124_idu #(
  parameter int unsigned          ISA_WIDTH = 32,
  parameter logic [ISA_WIDTH-1:0] RESET_PC  = 32'h80000000,
`ifdef IDU_RV32E_EN
  localparam int unsigned         REG_AW    = 4
`else
  localparam int unsigned         REG_AW    = 5
`endif
) (
  input  logic                 clk,
  input  logic                 idu_rst,
  input  logic [ISA_WIDTH-1:0] i_ins,
  input  logic [ISA_WIDTH-1:0] i_pc,
  input  logic                 i_pre_valid,
  output logic                 o_pre_ready,
  input  logic                 i_flush,
  output logic                 o_post_valid,
  input  logic                 i_post_ready,
  output logic [ISA_WIDTH-1:0] o_pc,
  output logic [ISA_WIDTH-1:0] o_ins,
  output logic [REG_AW-1:0]    o_rs1,
  output logic [REG_AW-1:0]    o_rs2,
  output logic [REG_AW-1:0]    o_rd,
  output logic [ISA_WIDTH-1:0] o_imm,
  output logic [9:0]           o_opclass,
  output logic                 o_rd_wen,
  output logic                 o_illegal
);

  // Opclass bit positions: {SYSTEM,OP,OPIMM,STORE,LOAD,BRANCH,JALR,JAL,AUIPC,LUI}
  localparam logic [9:0] CLS_WRITES_RD = 10'b11_1010_1111;
  localparam logic [9:0] CLS_USES_RS1  = 10'b11_1111_1000;
  localparam logic [9:0] CLS_USES_RS2  = 10'b01_0101_0000;

  logic                 r_valid;
  logic [ISA_WIDTH-1:0] r_ins;
  logic [ISA_WIDTH-1:0] r_pc;

  logic                 w_accept;
  logic [6:0]           w_opcode;
  logic [9:0]           w_opclass;
  logic [ISA_WIDTH-1:0] w_imm;
  logic [ISA_WIDTH-1:0] w_imm_i;
  logic [ISA_WIDTH-1:0] w_imm_s;
  logic [ISA_WIDTH-1:0] w_imm_b;
  logic [ISA_WIDTH-1:0] w_imm_u;
  logic [ISA_WIDTH-1:0] w_imm_j;
  logic                 w_writes_rd;
  logic                 w_illegal;

  // The entry can be refilled on the same cycle it drains, so a full-rate stream sees no bubble.
  assign o_pre_ready = ~r_valid | i_post_ready;
  assign w_accept    = i_pre_valid & o_pre_ready & ~i_flush;

  // One-entry pipeline register. Flush wins over accept. A drain without a refill empties the entry.
  always_ff @(posedge clk or negedge idu_rst) begin
    if (!idu_rst) begin
      r_valid <= 1'b0;
      r_ins   <= '0;
      r_pc    <= RESET_PC;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_ins   <= i_ins;
      r_pc    <= i_pc;
    end else if (r_valid && i_post_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_post_valid = r_valid;
  assign o_ins        = r_ins;
  assign o_pc         = r_pc;
  assign o_rs1        = r_ins[15 +: REG_AW];
  assign o_rs2        = r_ins[20 +: REG_AW];
  assign o_rd         = r_ins[7 +: REG_AW];
  assign w_opcode     = r_ins[6:0];

  // Opcode to one-hot class. Unknown opcodes give an all-zero class.
  always_comb begin
    w_opclass = '0;
    case (w_opcode)
      7'b0110111: w_opclass = 10'b00_0000_0001;
      7'b0010111: w_opclass = 10'b00_0000_0010;
      7'b1101111: w_opclass = 10'b00_0000_0100;
      7'b1100111: w_opclass = 10'b00_0000_1000;
      7'b1100011: w_opclass = 10'b00_0001_0000;
      7'b0000011: w_opclass = 10'b00_0010_0000;
      7'b0100011: w_opclass = 10'b00_0100_0000;
      7'b0010011: w_opclass = 10'b00_1000_0000;
      7'b0110011: w_opclass = 10'b01_0000_0000;
      7'b1110011: w_opclass = 10'b10_0000_0000;
      default:    w_opclass = '0;
    endcase
  end

  assign w_imm_i = ISA_WIDTH'(signed'(r_ins[31:20]));
  assign w_imm_s = ISA_WIDTH'(signed'({r_ins[31:25], r_ins[11:7]}));
  assign w_imm_b = ISA_WIDTH'(signed'({r_ins[31], r_ins[7], r_ins[30:25], r_ins[11:8], 1'b0}));
  assign w_imm_u = ISA_WIDTH'(signed'({r_ins[31:12], 12'b0}));
  assign w_imm_j = ISA_WIDTH'(signed'({r_ins[31], r_ins[19:12], r_ins[20], r_ins[30:21], 1'b0}));

  // Immediate format chosen by class. OP and unknown opcodes carry no immediate.
  always_comb begin
    w_imm = '0;
    if (w_opclass[0] || w_opclass[1]) begin
      w_imm = w_imm_u;
    end else if (w_opclass[2]) begin
      w_imm = w_imm_j;
    end else if (w_opclass[4]) begin
      w_imm = w_imm_b;
    end else if (w_opclass[6]) begin
      w_imm = w_imm_s;
    end else if (w_opclass[3] || w_opclass[5] || w_opclass[7] || w_opclass[9]) begin
      w_imm = w_imm_i;
    end
  end

  assign w_writes_rd = |(w_opclass & CLS_WRITES_RD);

`ifdef IDU_RV32E_EN
  logic w_reg_viol;
  assign w_reg_viol = (|(w_opclass & CLS_USES_RS1) & r_ins[19])
                    | (|(w_opclass & CLS_USES_RS2) & r_ins[24])
                    | (w_writes_rd & r_ins[11]);
  assign w_illegal  = ~|w_opclass | w_reg_viol;
`else
  logic w_unused_masks;
  assign w_unused_masks = |{CLS_USES_RS1, CLS_USES_RS2};
  assign w_illegal      = ~|w_opclass | (w_unused_masks & 1'b0);
`endif

  assign o_imm     = w_imm;
  assign o_opclass = w_opclass;
  assign o_illegal = w_illegal;
  assign o_rd_wen  = w_writes_rd & (r_ins[11:7] != 5'd0) & ~w_illegal;

endmodule

// File: tb/tb_ysyx_23060124_idu.sv
// tb_ysyx_23060124_idu: checks the decode stage in four phases.
//   - Reset values.
//   - A table of known instructions.
//   - Hand-written sequences for stall, flush, drain and async reset.
//   - A randomized stream checked against a queue-based reference model.
module tb_ysyx_23060124_idu;

  localparam logic [31:0] RESET_PC = 32'h80000000;

  // Opcode of each class, indexed by its one-hot bit position (LUI .. SYSTEM).
  localparam logic [6:0] OPCODES [10] = '{
    7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
    7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011
  };

  logic        clk;
  logic        idu_rst;
  logic [31:0] i_ins;
  logic [31:0] i_pc;
  logic        i_pre_valid;
  logic        o_pre_ready;
  logic        i_flush;
  logic        o_post_valid;
  logic        i_post_ready;
  logic [31:0] o_pc;
  logic [31:0] o_ins;
  logic [4:0]  o_rs1;
  logic [4:0]  o_rs2;
  logic [4:0]  o_rd;
  logic [31:0] o_imm;
  logic [9:0]  o_opclass;
  logic        o_rd_wen;
  logic        o_illegal;

  ysyx_23060124_idu dut (
    .clk         (clk),
    .idu_rst     (idu_rst),
    .i_ins       (i_ins),
    .i_pc        (i_pc),
    .i_pre_valid (i_pre_valid),
    .o_pre_ready (o_pre_ready),
    .i_flush     (i_flush),
    .o_post_valid(o_post_valid),
    .i_post_ready(i_post_ready),
    .o_pc        (o_pc),
    .o_ins       (o_ins),
    .o_rs1       (o_rs1),
    .o_rs2       (o_rs2),
    .o_rd        (o_rd),
    .o_imm       (o_imm),
    .o_opclass   (o_opclass),
    .o_rd_wen    (o_rd_wen),
    .o_illegal   (o_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the bench always ends on its own.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation ran past its time limit");
    $fatal(1, "[TB] timeout");
  end

  typedef struct {
    logic [9:0]  opclass;
    logic [31:0] imm;
    logic        rdWen;
    logic        illegal;
  } decodeT;

  typedef struct {
    logic [31:0] ins;
    logic [9:0]  opclass;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        rdWen;
    logic        illegal;
  } vecT;

  int nChecks = 0;
  int nFails  = 0;
  logic [63:0] modelQ[$];

  // Reference decode. The immediate is built from place values rather than bit concatenation.
  function automatic decodeT refDecode(input logic [31:0] ins);
    decodeT d;
    int cls;
    int immVal;
    cls    = -1;
    immVal = 0;
    for (int k = 0; k < 10; k++) begin
      if (ins[6:0] == OPCODES[k]) cls = k;
    end
    case (cls)
      0, 1: immVal = int'(ins & 32'hFFFFF000);
      2: immVal = (ins[31] ? -(1 << 20) : 0) + int'(ins[19:12]) * 4096
                  + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
      4: immVal = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048
                  + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      6: immVal = (int'($signed(ins)) >>> 25) * 32 + int'(ins[11:7]);
      3, 5, 7, 9: immVal = int'($signed(ins)) >>> 20;
      default: immVal = 0;
    endcase
    d.opclass = (cls >= 0) ? (10'd1 << cls) : 10'd0;
    d.imm     = 32'(immVal);
    d.illegal = (cls < 0);
    d.rdWen   = (cls >= 0) && (cls != 4) && (cls != 6) && (ins[11:7] != 5'd0);
    return d;
  endfunction

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] want);
    nChecks++;
    if (act !== want) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
    end
  endtask

  // Compares the DUT against the model entry. Fields are checked only while an entry is held.
  task automatic checkOutput();
    decodeT d;
    logic [31:0] ins;
    logic [31:0] pc;
    checkValue("o_post_valid", 32'(o_post_valid), 32'(modelQ.size() != 0));
    if (modelQ.size() != 0) begin
      ins = modelQ[0][63:32];
      pc  = modelQ[0][31:0];
      d   = refDecode(ins);
      checkValue("o_ins", o_ins, ins);
      checkValue("o_pc", o_pc, pc);
      checkValue("o_rs1", 32'(o_rs1), 32'(ins[19:15]));
      checkValue("o_rs2", 32'(o_rs2), 32'(ins[24:20]));
      checkValue("o_rd", 32'(o_rd), 32'(ins[11:7]));
      checkValue("o_imm", o_imm, d.imm);
      checkValue("o_opclass", 32'(o_opclass), 32'(d.opclass));
      checkValue("o_rd_wen", 32'(o_rd_wen), 32'(d.rdWen));
      checkValue("o_illegal", 32'(o_illegal), 32'(d.illegal));
    end
  endtask

  // Runs one clock cycle: drive inputs, check ready, advance the model, then check outputs.
  task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] pc,
                               input logic pv, input logic pr, input logic fl);
    logic readyWant;
    logic accept;
    @(negedge clk);
    i_ins        = ins;
    i_pc         = pc;
    i_pre_valid  = pv;
    i_post_ready = pr;
    i_flush      = fl;
    #1;
    readyWant = (modelQ.size() == 0) || pr;
    checkValue("o_pre_ready", 32'(o_pre_ready), 32'(readyWant));
    accept = pv && readyWant && !fl;
    if (fl) begin
      modelQ.delete();
    end else begin
      if (modelQ.size() != 0 && pr) void'(modelQ.pop_front());
      if (accept) modelQ.push_back({ins, pc});
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  vecT vecs [11];

  initial begin
    logic [31:0] pcVal;
    logic [31:0] rIns;

    vecs[0]  = '{32'h00500093, 10'h080, 5'd1,  5'd0,  5'd5,  32'h00000005, 1'b1, 1'b0};
    vecs[1]  = '{32'h123452B7, 10'h001, 5'd5,  5'd8,  5'd3,  32'h12345000, 1'b1, 1'b0};
    vecs[2]  = '{32'hFE208EE3, 10'h010, 5'd29, 5'd1,  5'd2,  32'hFFFFFFFC, 1'b0, 1'b0};
    vecs[3]  = '{32'hFFFFFFFF, 10'h000, 5'd31, 5'd31, 5'd31, 32'h00000000, 1'b0, 1'b1};
    vecs[4]  = '{32'h00000833, 10'h100, 5'd16, 5'd0,  5'd0,  32'h00000000, 1'b1, 1'b0};
    vecs[5]  = '{32'h008000EF, 10'h004, 5'd1,  5'd0,  5'd8,  32'h00000008, 1'b1, 1'b0};
    vecs[6]  = '{32'h00552623, 10'h040, 5'd12, 5'd10, 5'd5,  32'h0000000C, 1'b0, 1'b0};
    vecs[7]  = '{32'h00000013, 10'h080, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0, 1'b0};
    vecs[8]  = '{32'hFFFFF197, 10'h002, 5'd3,  5'd31, 5'd31, 32'hFFFFF000, 1'b1, 1'b0};
    vecs[9]  = '{32'hFFF100E7, 10'h008, 5'd1,  5'd2,  5'd31, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[10] = '{32'h00000073, 10'h200, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0, 1'b0};

    idu_rst      = 1'b0;
    i_ins        = '0;
    i_pc         = '0;
    i_pre_valid  = 1'b0;
    i_post_ready = 1'b0;
    i_flush      = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkValue("reset o_post_valid", 32'(o_post_valid), 32'd0);
    checkValue("reset o_ins", o_ins, 32'd0);
    checkValue("reset o_pc", o_pc, RESET_PC);
    checkValue("reset o_illegal", 32'(o_illegal), 32'd1);
    checkValue("reset o_opclass", 32'(o_opclass), 32'd0);
    checkValue("reset o_rd_wen", 32'(o_rd_wen), 32'd0);
    checkValue("reset o_pre_ready", 32'(o_pre_ready), 32'd1);
    @(negedge clk);
    idu_rst = 1'b1;

    $display("[TB] table of known instructions");
    pcVal = 32'h80000000;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].ins, pcVal, 1'b1, 1'b1, 1'b0);
      checkValue($sformatf("vec%0d valid", i), 32'(o_post_valid), 32'd1);
      checkValue($sformatf("vec%0d pc", i), o_pc, pcVal);
      checkValue($sformatf("vec%0d opclass", i), 32'(o_opclass), 32'(vecs[i].opclass));
      checkValue($sformatf("vec%0d rd", i), 32'(o_rd), 32'(vecs[i].rd));
      checkValue($sformatf("vec%0d rs1", i), 32'(o_rs1), 32'(vecs[i].rs1));
      checkValue($sformatf("vec%0d rs2", i), 32'(o_rs2), 32'(vecs[i].rs2));
      checkValue($sformatf("vec%0d imm", i), o_imm, vecs[i].imm);
      checkValue($sformatf("vec%0d rd_wen", i), 32'(o_rd_wen), 32'(vecs[i].rdWen));
      checkValue($sformatf("vec%0d illegal", i), 32'(o_illegal), 32'(vecs[i].illegal));
      pcVal = pcVal + 32'd4;
    end

    $display("[TB] drain with no refill");
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkValue("drain valid", 32'(o_post_valid), 32'd0);

    $display("[TB] stall for three cycles, then refill without a bubble");
    applyStimulus(32'h00500093, 32'h80000100, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(32'h123452B7, 32'h80000104, 1'b1, 1'b0, 1'b0);
      checkValue("stall o_ins", o_ins, 32'h00500093);
      checkValue("stall o_imm", o_imm, 32'd5);
      checkValue("stall o_pc", o_pc, 32'h80000100);
    end
    applyStimulus(32'h123452B7, 32'h80000104, 1'b1, 1'b1, 1'b0);
    checkValue("refill valid", 32'(o_post_valid), 32'd1);
    checkValue("refill o_ins", o_ins, 32'h123452B7);

    $display("[TB] flush against held entry and incoming word");
    applyStimulus(32'hFE208EE3, 32'h80000108, 1'b1, 1'b0, 1'b1);
    checkValue("flush held valid", 32'(o_post_valid), 32'd0);
    applyStimulus(32'hFE208EE3, 32'h8000010C, 1'b1, 1'b1, 1'b1);
    checkValue("flush empty valid", 32'(o_post_valid), 32'd0);

    $display("[TB] async reset while an entry is held");
    applyStimulus(32'h00500093, 32'h80000200, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    i_ins        = 32'hFE208EE3;
    i_pc         = 32'h80000204;
    i_pre_valid  = 1'b1;
    i_post_ready = 1'b1;
    idu_rst      = 1'b0;
    #1;
    checkValue("async reset valid", 32'(o_post_valid), 32'd0);
    checkValue("async reset o_ins", o_ins, 32'd0);
    checkValue("async reset o_pc", o_pc, RESET_PC);
    modelQ.delete();
    @(posedge clk);
    #1;
    checkValue("reset held valid", 32'(o_post_valid), 32'd0);
    @(negedge clk);
    i_pre_valid = 1'b0;
    idu_rst     = 1'b1;

    $display("[TB] randomized stream against reference model");
    for (int n = 0; n < 400; n++) begin
      rIns = $urandom();
      if ($urandom_range(0, 9) < 8) rIns[6:0] = OPCODES[$urandom_range(0, 9)];
      applyStimulus(rIns, $urandom(),
                    1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 11) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
